// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg
// Shared definitions for the register-file debug reader: register-file
// geometry (also used by the register file and CPU top) and the state
// encoding of the dump sequencer.
package reg_dump_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 3;
    localparam int NUM_REGS   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dump_state_t;

endpackage

// File: rtl/reg_dump_unit.sv
// reg_dump_unit
// Sequential debug reader for the CPU register file. On START it walks the
// address range FIRST_ADDR..LAST_ADDR (wrapping modulo NUM_REGS), drives each
// address onto a spare read port, captures the read data one edge later and
// presents {DOUT_ADDR, DOUT} to a consumer over a valid/ready handshake.
//
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   START               dump request, honoured only while idle
//   FIRST_ADDR          first register of the range (latched with START)
//   LAST_ADDR           last register of the range (latched with START)
//   RADDR               register-file read address
//   RDATA               register-file read data
//   DOUT, DOUT_ADDR     captured value and the register it came from
//   DOUT_VALID          beat valid
//   DOUT_READY          consumer accepts the current beat
//   DOUT_LAST           current beat is the last of the range
//   BUSY                a dump is in progress
//   DONE                one-cycle pulse after the final beat is accepted
module reg_dump_unit
    import reg_dump_pkg::*;
#(
    parameter int DATA_WIDTH = reg_dump_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = reg_dump_pkg::ADDR_WIDTH,
    parameter int NUM_REGS   = reg_dump_pkg::NUM_REGS
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [ADDR_WIDTH-1:0] FIRST_ADDR,
    input  logic [ADDR_WIDTH-1:0] LAST_ADDR,
    output logic [ADDR_WIDTH-1:0] RADDR,
    input  logic [DATA_WIDTH-1:0] RDATA,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic [ADDR_WIDTH-1:0] DOUT_ADDR,
    output logic                  DOUT_VALID,
    input  logic                  DOUT_READY,
    output logic                  DOUT_LAST,
    output logic                  BUSY,
    output logic                  DONE
);

    dump_state_t           r_state;
    dump_state_t           w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_end;
    logic [DATA_WIDTH-1:0] r_dout;
    logic [ADDR_WIDTH-1:0] r_dout_addr;
    logic                  r_dout_valid;
    logic                  r_dout_last;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_addr_inc;

    assign w_accept   = r_dout_valid & DOUT_READY;
    // Explicit wrap keeps the walk correct even if NUM_REGS is not a power of two.
    assign w_addr_inc = (r_addr == ADDR_WIDTH'(NUM_REGS - 1)) ? '0 : r_addr + 1'b1;

    // The address counter doubles as the read-port address: it is loaded on
    // START and only advances on an accepted beat, so RADDR is correct for
    // every READ cycle and simply holds its last value elsewhere.
    assign RADDR      = r_addr;
    assign DOUT       = r_dout;
    assign DOUT_ADDR  = r_dout_addr;
    assign DOUT_VALID = r_dout_valid;
    assign DOUT_LAST  = r_dout_last;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (START) w_state_nxt = ST_READ;
            ST_READ: w_state_nxt = ST_SEND;
            ST_SEND: begin
                if (w_accept) w_state_nxt = r_dout_last ? ST_DONE : ST_READ;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs
    always_comb begin
        BUSY = (r_state != ST_IDLE);
        DONE = (r_state == ST_DONE);
    end

    // Datapath: range registers, read capture and output beat.
    // A reset mid-dump drops the pending beat along with the sequence.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_addr       <= '0;
            r_end        <= '0;
            r_dout       <= '0;
            r_dout_addr  <= '0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_addr <= FIRST_ADDR;
                        r_end  <= LAST_ADDR;
                    end
                end
                ST_READ: begin
                    r_dout       <= RDATA;
                    r_dout_addr  <= r_addr;
                    r_dout_last  <= (r_addr == r_end);
                    r_dout_valid <= 1'b1;
                end
                ST_SEND: begin
                    if (w_accept) begin
                        r_dout_valid <= 1'b0;
                        if (!r_dout_last) r_addr <= w_addr_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/reg_dump_unit.md
# reg_dump_unit

Sequential debug reader for the 8x8 CPU register file. On a START request it walks a contiguous (optionally wrapping) address range, drives each address onto a spare register-file read port, captures the 8-bit read data and streams `{address, data}` out over a valid/ready handshake. It sits beside `cpu`/register file as the read-side counterpart to the writeback path and feeds a debug/trace consumer such as a UART transmitter or test-bench monitor.

## Interface
Parameters:
- `DATA_WIDTH`, 8, register width
- `ADDR_WIDTH`, 3, register address width
- `NUM_REGS`, 8, registers in file (= 2**ADDR_WIDTH)

Ports:
- `CLK`  in  1  clock
- `RESET`  in  1  reset, synchronous, active-high
- `START`  in  1  request a dump; sampled only in IDLE
- `FIRST_ADDR`  in  3  first register to read; sampled with START
- `LAST_ADDR`  in  3  last register to read; sampled with START
- `RADDR`  out  3  address to register-file read port
- `RDATA`  in  8  data from that read port
- `DOUT`  out  8  captured register value
- `DOUT_ADDR`  out  3  address `DOUT` came from
- `DOUT_VALID`  out  1  `DOUT`/`DOUT_ADDR`/`DOUT_LAST` valid
- `DOUT_READY`  in  1  consumer accepts the current beat
- `DOUT_LAST`  out  1  current beat is the final address of the range
- `BUSY`  out  1  high in every state except IDLE
- `DONE`  out  1  one-cycle pulse after the last beat is accepted

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE: `START`=1 -> latch `FIRST_ADDR` into address counter, `LAST_ADDR` into end register; go READ. `START` in any other state is ignored.
- READ: `RADDR` = address counter for the whole cycle. At next edge: `DOUT`<=`RDATA`, `DOUT_ADDR`<=counter, `DOUT_LAST`<=(counter==end), `DOUT_VALID`<=1; go SEND.
- SEND: hold `DOUT`, `DOUT_ADDR`, `DOUT_LAST`, `DOUT_VALID` stable while `DOUT_READY`=0. On edge with `DOUT_VALID & DOUT_READY`: `DOUT_VALID`<=0; if `DOUT_LAST` go DONE, else counter <= counter+1 mod NUM_REGS, go READ.
- DONE: `DONE`=1 for exactly this cycle; go IDLE.
- Address arithmetic: 3-bit wrap, 7+1 = 0. FIRST_ADDR > LAST_ADDR means a wrapping range (6..1 reads 6,7,0,1). FIRST_ADDR == LAST_ADDR reads one register. A full 8-register dump is 0..7 (or any k..k-1).
- Data captured is whatever `RDATA` shows at the capture edge; concurrent writes by the CPU are not blocked or detected.
- `RADDR` holds its last value outside READ.

## Timing
- Reset values: state IDLE, `RADDR`=0, `DOUT`=0, `DOUT_ADDR`=0, `DOUT_VALID`=0, `DOUT_LAST`=0, `BUSY`=0, `DONE`=0.
- `RESET` is sampled on `CLK` only; reset overrides everything, including an in-progress dump: beat dropped, no `DONE`.
- START sampled at edge k -> `RADDR`=FIRST_ADDR and `BUSY`=1 from k; `DOUT_VALID`=1 from edge k+1.
- Register-file read path settles within one `CLK` period; `RDATA` sampled one edge after `RADDR` is driven.
- Throughput: 2 cycles per register with `DOUT_READY` held high; N registers -> `DONE` pulse at edge k+2N, `BUSY` falls at k+2N+1.
- `DOUT_VALID` never deasserts without a handshake; `DOUT_READY` may toggle freely.
- START high in the DONE cycle is ignored; a new dump can start at the first IDLE cycle.

## Structure
- Shared package `reg_dump_pkg`: state encoding (IDLE=2'd0, READ=2'd1, SEND=2'd2, DONE=2'd3), `DATA_WIDTH`/`ADDR_WIDTH`/`NUM_REGS` constants reused by the register file and CPU top.
- Single flat module; no sub-module. Next-state logic and datapath registers are split into separate always blocks.

## Test plan
- Preload R0..R7 = 8'h10..8'h17, START FIRST=0 LAST=7, READY=1 -> 8 beats (0,10)..(7,17), `DOUT_LAST` only on addr 7, `DONE` at edge k+16.
- Same range, READY low for 3 cycles on each beat -> `DOUT`/`DOUT_ADDR` stable while stalled, same 8 beats in order, no loss or duplication.
- START FIRST=6 LAST=1 -> beats at addresses 6,7,0,1; LAST on 1.
- START FIRST=LAST=3, R3=8'hA5 -> single beat (3,A5) with LAST=1, then `DONE`.
- Second START pulsed mid-dump -> ignored; the original range completes unchanged.
- Assert RESET during a SEND with READY=0 -> next cycle all outputs at reset values, no `DONE`; a fresh START then works normally.
